// File: rtl/fir_pkg.sv
// Shared FIR constants, sample/coefficient types and MAC FSM states.
package fir_pkg;
   localparam int FIR_NTAPS  = 8;
   localparam int FIR_DATA_W = 16;
   localparam int FIR_COEF_W = 16;

   typedef logic signed [FIR_DATA_W-1:0] sample_t;
   typedef logic signed [FIR_COEF_W-1:0] coef_t;

   // 0.125 on every tap: eight-point moving average
   localparam coef_t FIR_COEFFS_DEFAULT [FIR_NTAPS] = '{default: 16'sh1000};

   typedef enum logic [1:0] {
      IDLE,
      MAC,
      ROUND
   } fir_mac_state_e;
endpackage

// File: rtl/fir_mac_seq_if.sv
// Tap-vector in / filtered-sample out handshake bundle.
interface fir_mac_seq_if
   import fir_pkg::*;
#(
   parameter int NTAPS  = FIR_NTAPS,
   parameter int DATA_W = FIR_DATA_W
);
   logic [NTAPS-1:0][DATA_W-1:0] taps_in;
   logic                         in_valid;
   logic                         in_ready;
   logic signed [DATA_W-1:0]     out_data;
   logic                         out_valid;

   modport master (
      output taps_in,
      output in_valid,
      input  in_ready,
      input  out_data,
      input  out_valid
   );

   modport slave (
      input  taps_in,
      input  in_valid,
      output in_ready,
      output out_data,
      output out_valid
   );
endinterface

// File: rtl/fir_round_sat.sv
// Round-half-up arithmetic right shift, then clamp to OUT_W signed.
module fir_round_sat #(
   parameter int IN_W  = 35,
   parameter int OUT_W = 16,
   parameter int SHIFT = 15
) (
   input  logic signed [IN_W-1:0]  acc,
   output logic signed [OUT_W-1:0] y
);
   localparam logic signed [IN_W-1:0] HALF =
      {{(IN_W-SHIFT){1'b0}}, 1'b1, {(SHIFT-1){1'b0}}};
   localparam logic signed [IN_W-1:0] MAXV =
      {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [IN_W-1:0] MINV =
      {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

   logic signed [IN_W-1:0] sh;

   // IN_W carries enough headroom that adding HALF cannot wrap
   always_comb begin
      sh = (acc + HALF) >>> SHIFT;
      if (sh > MAXV) begin
         y = MAXV[OUT_W-1:0];
      end else if (sh < MINV) begin
         y = MINV[OUT_W-1:0];
      end else begin
         y = sh[OUT_W-1:0];
      end
   end
endmodule

// File: rtl/fir_mac_seq.sv
// Sequential FIR multiply-accumulate: one shared multiplier,
// one rounded/saturated result per NTAPS+2 cycles.
module fir_mac_seq
   import fir_pkg::*;
#(
   parameter int NTAPS  = FIR_NTAPS,
   parameter int DATA_W = FIR_DATA_W,
   parameter int COEF_W = FIR_COEF_W,
   parameter logic signed [COEF_W-1:0] COEFFS [NTAPS] = FIR_COEFFS_DEFAULT
) (
   input logic          clk,
   input logic          reset,
   fir_mac_seq_if.slave bus
);
   localparam int ACC_W  = DATA_W + COEF_W + $clog2(NTAPS);
   localparam int PROD_W = DATA_W + COEF_W;
   localparam int IDX_W  = $clog2(NTAPS);
   localparam logic [IDX_W-1:0] LAST = IDX_W'(NTAPS - 1);

   fir_mac_state_e               state_q, state_d;
   logic [NTAPS-1:0][DATA_W-1:0] snap_q, snap_d;
   logic signed [ACC_W-1:0]      acc_q, acc_d;
   logic [IDX_W-1:0]             idx_q, idx_d;
   logic signed [DATA_W-1:0]     dout_q, dout_d;
   logic                         oval_q, oval_d;

   logic signed [PROD_W-1:0] tap_x, coef_x, prod;
   logic signed [ACC_W-1:0]  prod_x;
   logic signed [DATA_W-1:0] rounded;

   // Both operands widened to the full product width before multiply
   always_comb begin
      tap_x  = {{COEF_W{snap_q[idx_q][DATA_W-1]}}, snap_q[idx_q]};
      coef_x = {{DATA_W{COEFFS[idx_q][COEF_W-1]}}, COEFFS[idx_q]};
      prod   = tap_x * coef_x;
      prod_x = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
   end

   fir_round_sat #(
      .IN_W  (ACC_W),
      .OUT_W (DATA_W),
      .SHIFT (COEF_W - 1)
   ) u_round_sat (
      .acc (acc_q),
      .y   (rounded)
   );

   always_comb begin
      state_d = state_q;
      snap_d  = snap_q;
      acc_d   = acc_q;
      idx_d   = idx_q;
      dout_d  = dout_q;
      oval_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               snap_d  = bus.taps_in;
               acc_d   = '0;
               idx_d   = '0;
               state_d = MAC;
            end
         end
         MAC: begin
            acc_d = acc_q + prod_x;
            idx_d = idx_q + 1'b1;
            if (idx_q == LAST) begin
               state_d = ROUND;
            end
         end
         ROUND: begin
            dout_d  = rounded;
            oval_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         snap_q  <= '0;
         acc_q   <= '0;
         idx_q   <= '0;
         dout_q  <= '0;
         oval_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         snap_q  <= snap_d;
         acc_q   <= acc_d;
         idx_q   <= idx_d;
         dout_q  <= dout_d;
         oval_q  <= oval_d;
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_data  = dout_q;
   assign bus.out_valid = oval_q;
endmodule

// File: tb/tb_fir_mac_seq.sv
// Directed bench for fir_mac_seq: three instances share one stimulus
// stream (moving-average, single-tap half gain, full-scale gain).
module tb_fir_mac_seq;
   localparam int NT = 8;
   typedef logic [NT-1:0][15:0] tapv_t;

   logic  clk = 1'b0;
   logic  reset;
   tapv_t taps;
   logic  in_valid;
   int    n_chk = 0;
   int    n_fail = 0;

   always #5 clk = ~clk;

   fir_mac_seq_if #(.NTAPS(NT), .DATA_W(16)) if_avg ();
   fir_mac_seq_if #(.NTAPS(NT), .DATA_W(16)) if_rnd ();
   fir_mac_seq_if #(.NTAPS(NT), .DATA_W(16)) if_sat ();

   assign if_avg.taps_in  = taps;
   assign if_avg.in_valid = in_valid;
   assign if_rnd.taps_in  = taps;
   assign if_rnd.in_valid = in_valid;
   assign if_sat.taps_in  = taps;
   assign if_sat.in_valid = in_valid;

   fir_mac_seq #(.NTAPS(NT)) u_avg (
      .clk   (clk),
      .reset (reset),
      .bus   (if_avg)
   );

   fir_mac_seq #(
      .NTAPS  (NT),
      .COEFFS ('{16'sh4000, 16'sh0, 16'sh0, 16'sh0,
                 16'sh0, 16'sh0, 16'sh0, 16'sh0})
   ) u_rnd (
      .clk   (clk),
      .reset (reset),
      .bus   (if_rnd)
   );

   fir_mac_seq #(
      .NTAPS  (NT),
      .COEFFS ('{default: 16'sh7FFF})
   ) u_sat (
      .clk   (clk),
      .reset (reset),
      .bus   (if_sat)
   );

   function automatic tapv_t fill(input int x);
      tapv_t r;
      for (int i = 0; i < NT; i++) r[i] = 16'(x);
      return r;
   endfunction

   // Independent arithmetic model of the moving-average instance
   function automatic logic signed [15:0] exp_avg(input tapv_t v);
      longint s = 0;
      for (int i = 0; i < NT; i++) begin
         s += longint'($signed(v[i])) * 64'sd4096;
      end
      s = (s + 64'sd16384) >>> 15;
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
      return 16'(s);
   endfunction

   // Drive one tap vector; lat = edges from accept to out_valid
   task automatic run_sample(input tapv_t v, output int lat);
      int w = 0;
      @(negedge clk);
      while (!if_avg.in_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      if (!if_avg.in_ready) begin
         lat = -2;
         return;
      end
      taps = v;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = -1;
      for (int n = 1; n <= 20; n++) begin
         @(posedge clk);
         #1;
         if (if_avg.out_valid) begin
            lat = n;
            break;
         end
      end
   endtask

   task automatic test_reset();
      int bad = 0;
      reset = 1'b1;
      in_valid = 1'b0;
      taps = '0;
      #12;
      n_chk++;
      if (if_avg.in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_in_ready: got %b expected 1", if_avg.in_ready);
      end
      n_chk++;
      if (if_avg.out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_out_valid: got %b expected 0", if_avg.out_valid);
      end
      n_chk++;
      if (if_avg.out_data !== 16'sd0) begin
         n_fail++;
         $display("FAIL reset_out_data: got %0d expected 0", if_avg.out_data);
      end
      @(negedge clk);
      reset = 1'b0;
      repeat (20) begin
         @(posedge clk);
         #1;
         if (if_avg.in_ready !== 1'b1 || if_avg.out_valid !== 1'b0 ||
             if_avg.out_data !== 16'sd0) bad++;
      end
      n_chk++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL idle_hold: got %0d bad cycles expected 0", bad);
      end
   endtask

   task automatic test_moving_avg();
      int lat;
      logic signed [15:0] e;
      run_sample(fill(1000), lat);
      n_chk++;
      if (lat != NT + 1) begin
         n_fail++;
         $display("FAIL avg_latency: got %0d expected %0d", lat, NT + 1);
      end
      e = 16'sd1000;
      n_chk++;
      if (if_avg.out_data !== e) begin
         n_fail++;
         $display("FAIL avg_pos: got %0d expected %0d", if_avg.out_data, e);
      end
      @(posedge clk);
      #1;
      n_chk++;
      if (if_avg.out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL avg_pulse_width: got %b expected 0", if_avg.out_valid);
      end
      repeat (3) @(posedge clk);
      #1;
      n_chk++;
      if (if_avg.out_data !== e) begin
         n_fail++;
         $display("FAIL avg_hold: got %0d expected %0d", if_avg.out_data, e);
      end
      run_sample(fill(-1000), lat);
      e = -16'sd1000;
      n_chk++;
      if (lat != NT + 1 || if_avg.out_data !== e) begin
         n_fail++;
         $display("FAIL avg_neg: got %0d (lat %0d) expected %0d",
                  if_avg.out_data, lat, e);
      end
   endtask

   task automatic test_rounding();
      int lat;
      tapv_t v;
      logic signed [15:0] e;
      v = fill(500);
      v[0] = 16'd3;
      run_sample(v, lat);
      e = 16'sd2;
      n_chk++;
      if (lat != NT + 1 || if_rnd.out_data !== e) begin
         n_fail++;
         $display("FAIL round_pos: got %0d (lat %0d) expected %0d",
                  if_rnd.out_data, lat, e);
      end
      v[0] = 16'hFFFD;
      run_sample(v, lat);
      e = -16'sd1;
      n_chk++;
      if (lat != NT + 1 || if_rnd.out_data !== e) begin
         n_fail++;
         $display("FAIL round_neg: got %0d (lat %0d) expected %0d",
                  if_rnd.out_data, lat, e);
      end
   endtask

   task automatic test_saturation();
      int lat;
      logic signed [15:0] e;
      run_sample(fill(32767), lat);
      e = 16'sd32767;
      n_chk++;
      if (lat != NT + 1 || if_sat.out_data !== e) begin
         n_fail++;
         $display("FAIL sat_pos: got %0d (lat %0d) expected %0d",
                  if_sat.out_data, lat, e);
      end
      run_sample(fill(-32768), lat);
      e = 16'h8000;
      n_chk++;
      if (if_sat.out_data !== e) begin
         n_fail++;
         $display("FAIL sat_neg: got %0d expected %0d", if_sat.out_data, e);
      end
      n_chk++;
      if (if_avg.out_data !== e) begin
         n_fail++;
         $display("FAIL avg_min_exact: got %0d expected %0d",
                  if_avg.out_data, e);
      end
   endtask

   task automatic test_back_to_back();
      int acc_cyc[$];
      logic signed [15:0] expq[$];
      logic signed [15:0] e;
      tapv_t vv;
      int nres = 0;
      for (int c = 0; c < 52; c++) begin
         @(negedge clk);
         if (c < 40) begin
            for (int i = 0; i < NT; i++) vv[i] = 16'(c * 37 + i * 113 - 400);
            taps = vv;
            in_valid = 1'b1;
            if (if_avg.in_ready) begin
               expq.push_back(exp_avg(vv));
               acc_cyc.push_back(c);
            end
         end else begin
            in_valid = 1'b0;
         end
         @(posedge clk);
         #1;
         if (if_avg.out_valid) begin
            nres++;
            n_chk++;
            if (expq.size() == 0) begin
               n_fail++;
               $display("FAIL b2b_spurious: got %0d expected no result",
                        if_avg.out_data);
            end else begin
               e = expq.pop_front();
               if (if_avg.out_data !== e) begin
                  n_fail++;
                  $display("FAIL b2b_result: got %0d expected %0d",
                           if_avg.out_data, e);
               end
            end
         end
      end
      n_chk++;
      if (acc_cyc.size() != 4 || nres != 4) begin
         n_fail++;
         $display("FAIL b2b_count: got %0d accepts %0d results expected 4 4",
                  acc_cyc.size(), nres);
      end
      for (int i = 1; i < acc_cyc.size(); i++) begin
         n_chk++;
         if (acc_cyc[i] - acc_cyc[i-1] != NT + 2) begin
            n_fail++;
            $display("FAIL b2b_spacing: got %0d expected %0d",
                     acc_cyc[i] - acc_cyc[i-1], NT + 2);
         end
      end
   endtask

   task automatic test_reset_mid();
      int lat;
      int seen = 0;
      @(negedge clk);
      taps = fill(2000);
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      n_chk++;
      if (if_avg.out_data !== 16'sd0 || if_avg.out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_outputs: got data %0d valid %b expected 0 0",
                  if_avg.out_data, if_avg.out_valid);
      end
      n_chk++;
      if (if_avg.in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL abort_ready: got %b expected 1", if_avg.in_ready);
      end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (15) begin
         @(posedge clk);
         #1;
         if (if_avg.out_valid) seen++;
      end
      n_chk++;
      if (seen != 0 || if_avg.out_data !== 16'sd0) begin
         n_fail++;
         $display("FAIL abort_no_result: got %0d pulses data %0d expected 0 0",
                  seen, if_avg.out_data);
      end
      run_sample(fill(300), lat);
      n_chk++;
      if (lat != NT + 1 || if_avg.out_data !== 16'sd300) begin
         n_fail++;
         $display("FAIL after_abort: got %0d (lat %0d) expected 300",
                  if_avg.out_data, lat);
      end
   endtask

   initial begin
      test_reset();
      test_moving_avg();
      test_rounding();
      test_saturation();
      test_back_to_back();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
